// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: control inputs, instruction-memory port and the decoded head of the
// instruction buffer. The master side is the fetch unit; the slave side is its environment.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 25
);
  logic              FetchEnable;
  logic              Redirect;
  logic [ADDR_W-1:0] RedirectAddr;
  logic [ADDR_W-1:0] IMemAddr;
  logic              IMemRead;
  logic [INST_W-1:0] IMemData;
  logic              InstValid;
  logic              InstReady;
  logic [4:0]        Opcode;
  logic [3:0]        Destin;
  logic [3:0]        Source1;
  logic [3:0]        Source2;
  logic [7:0]        Imm;
  logic [ADDR_W-1:0] InstPC;

  modport master (
    input  FetchEnable, Redirect, RedirectAddr, IMemData, InstReady,
    output IMemAddr, IMemRead, InstValid, Opcode, Destin, Source1, Source2, Imm, InstPC
  );

  modport slave (
    output FetchEnable, Redirect, RedirectAddr, IMemData, InstReady,
    input  IMemAddr, IMemRead, InstValid, Opcode, Destin, Source1, Source2, Imm, InstPC
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues reads to a one-cycle-latency instruction memory and
// buffers returned words with their fetch address in a 2-entry FIFO.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INST_W   = 25,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                     clk,
  input logic                     Reset,
  instruction_fetch_unit_if.master bus
);

  logic [ADDR_W-1:0] fp_q, fp_d;
  logic [ADDR_W-1:0] reqPc_q, reqPc_d;
  logic              inFlight_q, inFlight_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [INST_W-1:0] inst0_q, inst0_d, inst1_q, inst1_d;
  logic [ADDR_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;

  logic              pop, push, issue, headValid;
  logic [1:0]        occ, afterPop;
  logic [ADDR_W-1:0] memAddr;

  // occ counts buffered plus in-flight words; a new read is allowed only if it still fits
  always_comb begin
    headValid = (cnt_q != 2'd0);
    occ       = cnt_q + {1'b0, inFlight_q};
    pop       = headValid && bus.InstReady && !bus.Redirect;
    push      = inFlight_q && !bus.Redirect;
    memAddr   = bus.Redirect ? bus.RedirectAddr : fp_q;
    if (Reset) begin
      issue = 1'b0;
    end else if (bus.Redirect) begin
      issue = bus.FetchEnable;
    end else begin
      issue = bus.FetchEnable && ((occ < 2'd2) || ((occ == 2'd2) && pop));
    end
  end

  always_comb begin
    fp_d       = issue ? memAddr + ADDR_W'(1) : memAddr;
    inFlight_d = issue;
    reqPc_d    = memAddr;
    cnt_d      = cnt_q;
    inst0_d    = inst0_q;
    inst1_d    = inst1_q;
    pc0_d      = pc0_q;
    pc1_d      = pc1_q;
    afterPop   = cnt_q - {1'b0, pop};
    if (bus.Redirect) begin
      cnt_d = 2'd0;
    end else begin
      if (pop) begin
        inst0_d = inst1_q;
        pc0_d   = pc1_q;
      end
      // The returning word lands in the first free slot left after this cycle's pop
      if (push) begin
        if (afterPop == 2'd0) begin
          inst0_d = bus.IMemData;
          pc0_d   = reqPc_q;
        end else begin
          inst1_d = bus.IMemData;
          pc1_d   = reqPc_q;
        end
      end
      cnt_d = afterPop + {1'b0, push};
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      fp_q       <= RESET_PC;
      reqPc_q    <= '0;
      inFlight_q <= 1'b0;
      cnt_q      <= 2'd0;
      inst0_q    <= '0;
      inst1_q    <= '0;
      pc0_q      <= '0;
      pc1_q      <= '0;
    end else begin
      fp_q       <= fp_d;
      reqPc_q    <= reqPc_d;
      inFlight_q <= inFlight_d;
      cnt_q      <= cnt_d;
      inst0_q    <= inst0_d;
      inst1_q    <= inst1_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
    end
  end

  assign bus.IMemAddr  = memAddr;
  assign bus.IMemRead  = issue;
  assign bus.InstValid = headValid;
  assign bus.Opcode    = headValid ? inst0_q[24:20] : 5'd0;
  assign bus.Destin    = headValid ? inst0_q[19:16] : 4'd0;
  assign bus.Source1   = headValid ? inst0_q[15:12] : 4'd0;
  assign bus.Source2   = headValid ? inst0_q[11:8]  : 4'd0;
  assign bus.Imm       = headValid ? inst0_q[7:0]   : 8'd0;
  assign bus.InstPC    = headValid ? pc0_q : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a cycle table from reset release,
// then scoreboarded streams covering reset, redirect, field decode, wrap and drain.
module tb_instruction_fetch_unit;

  typedef struct packed {
    logic [7:0]  pc;
    logic [24:0] word;
  } sbItem_t;

  typedef struct {
    logic       fe;
    logic       rdy;
    logic       rd;
    logic [7:0] ra;
    logic       expRead;
    logic [7:0] expAddr;
    logic       expValid;
    logic [7:0] expPc;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [24:0] mem [256];
  logic [24:0] memData;
  logic [31:0] rnd;
  sbItem_t     sbQ[$];
  sbItem_t     item;
  logic        sbOn;
  int          sbPopped;
  int          total;
  int          bad;
  int          p0;
  vec_t        vecs [13];

  instruction_fetch_unit_if #(.ADDR_W(8), .INST_W(25)) bus ();

  instruction_fetch_unit #(.ADDR_W(8), .INST_W(25), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: data for a read appears in the following cycle
  always @(posedge clk) begin
    if (bus.IMemRead) memData <= mem[bus.IMemAddr];
  end
  assign bus.IMemData = memData;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic rdy, input logic rd, input logic [7:0] ra);
    bus.FetchEnable  = fe;
    bus.InstReady    = rdy;
    bus.Redirect     = rd;
    bus.RedirectAddr = ra;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadQueue(input logic [7:0] start, input int n);
    logic [7:0] a;
    sbQ.delete();
    for (int i = 0; i < n; i++) begin
      a = start + 8'(i);
      sbQ.push_back('{pc: a, word: mem[a]});
    end
    sbPopped = 0;
    sbOn     = 1'b1;
  endtask

  task automatic redirectTo(input logic [7:0] start, input int n);
    applyStimulus(1'b1, 1'b1, 1'b1, start);
    loadQueue(start, n);
    @(negedge clk);
    checkOutput("redirect_addr", 32'(bus.IMemAddr), 32'(start));
    checkOutput("redirect_read", 32'(bus.IMemRead), 32'd1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic waitPops(input int n);
    int budget;
    budget = 0;
    while (sbPopped < n && budget < n + 10) begin
      tick();
      budget++;
    end
    checkOutput("stream_pops_reached", 32'(sbPopped >= n), 32'd1);
  endtask

  // Scoreboard: every accepted head must match the next expected {pc, word}
  always @(negedge clk) begin
    if (sbOn && bus.InstValid && bus.InstReady && !bus.Redirect) begin
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sb_unexpected: got pc %0h, want no instruction", bus.InstPC);
      end else begin
        item = sbQ.pop_front();
        checkOutput("sb_pc", 32'(bus.InstPC), 32'(item.pc));
        checkOutput("sb_word", 32'({bus.Opcode, bus.Destin, bus.Source1, bus.Source2, bus.Imm}),
                    32'(item.word));
      end
      sbPopped++;
    end
  end

  initial begin
    #50000;
    total++;
    bad++;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    total    = 0;
    bad      = 0;
    sbOn     = 1'b0;
    sbPopped = 0;
    memData  = '0;
    for (int k = 0; k < 256; k++) mem[k] = 25'(k);

    // Cycle table from reset release; memory word k = k, so Imm equals the head PC
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 8'h00};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h00};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h01};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h02};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 8'h03};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 8'h40, 1'b1, 8'h04};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 8'h00};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h42, 1'b1, 8'h40};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h43, 1'b1, 8'h41};

    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    tick();
    @(negedge clk);
    checkOutput("rst_read", 32'(bus.IMemRead), 32'd0);
    checkOutput("rst_valid", 32'(bus.InstValid), 32'd0);
    checkOutput("rst_pc", 32'(bus.InstPC), 32'd0);
    checkOutput("rst_opcode", 32'(bus.Opcode), 32'd0);
    checkOutput("rst_imm", 32'(bus.Imm), 32'd0);
    checkOutput("rst_addr", 32'(bus.IMemAddr), 32'h00);

    tick();
    reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].fe, vecs[i].rdy, vecs[i].rd, vecs[i].ra);
      @(negedge clk);
      checkOutput($sformatf("row%0d_read", i), 32'(bus.IMemRead), 32'(vecs[i].expRead));
      checkOutput($sformatf("row%0d_addr", i), 32'(bus.IMemAddr), 32'(vecs[i].expAddr));
      checkOutput($sformatf("row%0d_valid", i), 32'(bus.InstValid), 32'(vecs[i].expValid));
      checkOutput($sformatf("row%0d_pc", i), 32'(bus.InstPC), 32'(vecs[i].expPc));
      checkOutput($sformatf("row%0d_imm", i), 32'(bus.Imm), 32'(vecs[i].expPc));
      checkOutput($sformatf("row%0d_opcode", i), 32'(bus.Opcode), 32'd0);
      tick();
    end

    // Reset mid-stream with one buffered word and one read in flight
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("prerst_valid", 32'(bus.InstValid), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(bus.InstValid), 32'd0);
    checkOutput("midrst_read", 32'(bus.IMemRead), 32'd0);
    checkOutput("midrst_pc", 32'(bus.InstPC), 32'd0);
    checkOutput("midrst_imm", 32'(bus.Imm), 32'd0);
    loadQueue(8'h00, 20);
    tick();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("rel_read", 32'(bus.IMemRead), 32'd1);
    checkOutput("rel_addr", 32'(bus.IMemAddr), 32'h00);
    checkOutput("rel_valid_c0", 32'(bus.InstValid), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("rel_valid_c1", 32'(bus.InstValid), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("rel_valid_c2", 32'(bus.InstValid), 32'd1);
    checkOutput("rel_pc_c2", 32'(bus.InstPC), 32'h00);
    repeat (6) tick();
    checkOutput("rel_throughput", 32'(sbPopped), 32'd6);

    // Field decode of 25'h1A5C3F7: 11010 | 0101 | 1100 | 0011 | 11110111
    for (int k = 0; k < 256; k++) begin
      rnd    = $urandom;
      mem[k] = rnd[24:0];
    end
    mem[8'h10] = 25'h1A5C3F7;
    redirectTo(8'h10, 20);
    @(negedge clk);
    checkOutput("r10_valid_gap", 32'(bus.InstValid), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("r10_pc", 32'(bus.InstPC), 32'h10);
    checkOutput("r10_opcode", 32'(bus.Opcode), 32'h1A);
    checkOutput("r10_destin", 32'(bus.Destin), 32'h5);
    checkOutput("r10_src1", 32'(bus.Source1), 32'hC);
    checkOutput("r10_src2", 32'(bus.Source2), 32'h3);
    checkOutput("r10_imm", 32'(bus.Imm), 32'hF7);
    waitPops(4);

    // Fetch pointer wraps FE, FF, 00, 01, ...
    redirectTo(8'hFE, 20);
    @(negedge clk);
    checkOutput("wrap_valid_gap", 32'(bus.InstValid), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("wrap_first_pc", 32'(bus.InstPC), 32'hFE);
    waitPops(6);

    // FetchEnable low: in-flight word still captured, buffer drains, then empty
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    p0 = sbPopped;
    @(negedge clk);
    checkOutput("drain_read_d0", 32'(bus.IMemRead), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("drain_read_d1", 32'(bus.IMemRead), 32'd0);
    checkOutput("drain_valid_d1", 32'(bus.InstValid), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    repeat (3) tick();
    checkOutput("drain_count", 32'(sbPopped - p0), 32'd2);
    @(negedge clk);
    checkOutput("drain_empty", 32'(bus.InstValid), 32'd0);
    checkOutput("drain_read_end", 32'(bus.IMemRead), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
